// File: rtl/data_bus_mapper.sv
`default_nettype none
// data_bus_mapper: routes MemoryAccess-stage loads/stores to on-chip data memory,
// one of N peripheral channels (req/ack with timeout), or an unmapped-access fault.
// Revision: 1.0
module data_bus_mapper #(
  parameter int              AW              = 64,
  parameter int              N_PERIPH        = 4,
  parameter logic [AW-1:0]   PERIPH_BASE     = AW'(64'h400),
  parameter int              PERIPH_WIN_LOG2 = 8,
  parameter logic [AW-1:0]   MEM_BASE        = AW'(64'h800),
  parameter int              MEM_LOG2        = 11,
  parameter int              TIMEOUT         = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AW-1:0]             mr,
  input  logic [63:0]               mqb,
  input  logic                      mwmem,
  input  logic                      mrmem,
  input  logic [2:0]                mfunc3,
  output logic [63:0]               md,
  output logic                      stall,
  output logic                      fault,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_LOG2-1:0]       mem_addr,
  output logic [63:0]               mem_wdata,
  output logic [2:0]                mem_func3,
  input  logic [63:0]               mem_rdata,
  output logic [N_PERIPH-1:0]       p_sel,
  output logic                      p_we,
  output logic [PERIPH_WIN_LOG2-1:0] p_addr,
  output logic [63:0]               p_wdata,
  output logic [1:0]                p_size,
  input  logic [64*N_PERIPH-1:0]    p_rdata,
  input  logic [N_PERIPH-1:0]       p_ack
);

  localparam int            CNT_W    = $clog2(TIMEOUT);
  localparam logic [AW-1:0] MEM_SIZE = AW'(1) << MEM_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_MEM, SEL_PERIPH} sel_t;

  state_t                     state_q, state_d;
  sel_t                       sel_q, sel_d;
  logic                       fault_q, fault_d;
  logic [63:0]                rdata_q, rdata_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       to_q, to_d;
  logic                       uns_q, uns_d;
  logic [N_PERIPH-1:0]        psel_q, psel_d;
  logic                       pwe_q, pwe_d;
  logic [PERIPH_WIN_LOG2-1:0] paddr_q, paddr_d;
  logic [63:0]                pwdata_q, pwdata_d;
  logic [1:0]                 psize_q, psize_d;

  logic                       w_req, w_mem_hit, w_aligned, w_periph_go, w_ack;
  logic [N_PERIPH-1:0]        w_hit;
  logic [63:0]                w_prdata;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'd0:    return uns ? {56'd0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      2'd1:    return uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'd2:    return uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Windows are assumed naturally aligned, so in-window offsets are the low address bits.
  always_comb begin
    w_mem_hit = (mr >= MEM_BASE) && (mr < MEM_BASE + MEM_SIZE);
    w_hit     = '0;
    for (int i = 0; i < N_PERIPH; i++) begin
      if ((mr >= PERIPH_BASE + (AW'(i) << PERIPH_WIN_LOG2)) &&
          (mr <  PERIPH_BASE + (AW'(i + 1) << PERIPH_WIN_LOG2)))
        w_hit[i] = 1'b1;
    end
    case (mfunc3[1:0])
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = (mr[0] == 1'b0);
      2'd2:    w_aligned = (mr[1:0] == 2'b00);
      default: w_aligned = (mr[2:0] == 3'b000);
    endcase
    w_prdata = '0;
    for (int i = 0; i < N_PERIPH; i++) begin
      if (psel_q[i])
        w_prdata = w_prdata | p_rdata[64*i +: 64];
    end
  end

  assign w_req       = (state_q == S_IDLE) && (mwmem || mrmem);
  assign w_periph_go = w_req && !w_mem_hit && (|w_hit) && w_aligned;
  assign w_ack       = |(p_ack & psel_q);

  assign mem_en    = w_req && w_mem_hit;
  assign mem_we    = mem_en && mwmem;
  assign mem_addr  = mr[MEM_LOG2-1:0];
  assign mem_wdata = mqb;
  assign mem_func3 = mfunc3;
  assign stall     = w_periph_go || (state_q == S_BUSY);

  always_comb begin
    state_d  = state_q;
    sel_d    = SEL_NONE;
    fault_d  = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    uns_d    = uns_q;
    psel_d   = psel_q;
    pwe_d    = pwe_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    psize_d  = psize_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (w_mem_hit) begin
            sel_d = mwmem ? SEL_NONE : SEL_MEM;
          end else if (w_periph_go) begin
            state_d  = S_BUSY;
            psel_d   = w_hit;
            pwe_d    = mwmem;
            paddr_d  = mr[PERIPH_WIN_LOG2-1:0];
            pwdata_d = mqb;
            psize_d  = mfunc3[1:0];
            uns_d    = mfunc3[2];
            cnt_d    = '0;
            to_d     = 1'b0;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (w_ack) begin
          rdata_d = pwe_q ? 64'd0 : extend(w_prdata, psize_q, uns_q);
          psel_d  = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = 64'd0;
          to_d    = 1'b1;
          psel_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        sel_d   = SEL_PERIPH;
        fault_d = to_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      sel_q    <= SEL_NONE;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      uns_q    <= 1'b0;
      psel_q   <= '0;
      pwe_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      psize_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      uns_q    <= uns_d;
      psel_q   <= psel_d;
      pwe_q    <= pwe_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      psize_q  <= psize_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_MEM:    md = mem_rdata;
      SEL_PERIPH: md = rdata_q;
      default:    md = 64'd0;
    endcase
  end

  assign fault   = fault_q;
  assign p_sel   = psel_q;
  assign p_we    = pwe_q;
  assign p_addr  = paddr_q;
  assign p_wdata = pwdata_q;
  assign p_size  = psize_q;

endmodule
`default_nettype wire
